// File: rtl/req_latch_pkg.sv
// Shared constants and width helpers for the request latch bank.
package req_latch_pkg;

  localparam int DEFAULT_WIDTH = 4;

  function automatic int count_width(input int width);
    return $clog2(width + 1);
  endfunction

  // A single-bit bank still needs a 1-bit index port.
  function automatic int index_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/request_latch_bit.sv
// One sticky request bit: clear beats set. Define REQ_LATCH_EDGE_EN to
// latch only on rising edges of the request input.
module request_latch_bit (
  input  logic CLK,
  input  logic RESET,
  input  logic in,
  input  logic clr,
  output logic out
);

  logic set;

`ifdef REQ_LATCH_EDGE_EN
  logic prev;

  // History resets low so an input already high at reset release counts as a press.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) prev <= 1'b0;
    else       prev <= in;
  end

  assign set = in & ~prev;
`else
  assign set = in;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)    out <= 1'b0;
    else if (clr) out <= 1'b0;
    else if (set) out <= 1'b1;
  end

endmodule

// File: rtl/request_latch.sv
// Bank of sticky call-button request latches with combinational summaries.
// Edge-triggered capture is selected by defining REQ_LATCH_EDGE_EN.
module request_latch
  import req_latch_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic [WIDTH-1:0]              in,
  input  logic [WIDTH-1:0]              clr,
  output logic [WIDTH-1:0]              out,
  output logic                          any,
  output logic [count_width(WIDTH)-1:0] count,
  output logic [index_width(WIDTH)-1:0] lowest,
  output logic                          lowest_valid
);

  localparam int CW = count_width(WIDTH);
  localparam int IW = index_width(WIDTH);

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    request_latch_bit u_bit (
      .CLK   (CLK),
      .RESET (RESET),
      .in    (in[g]),
      .clr   (clr[g]),
      .out   (out[g])
    );
  end

  assign any          = |out;
  assign lowest_valid = any;

  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) count = count + CW'(out[i]);
  end

  // Scan from the top so the lowest set bit wins.
  always_comb begin
    lowest = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (out[i]) lowest = IW'(i);
    end
  end

endmodule

// File: tb/tb_request_latch.sv
// Directed self-checking bench for request_latch (level or edge build).
module tb_request_latch;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [3:0] in = '0;
  logic [3:0] clr = '0;
  logic [3:0] out;
  logic       any;
  logic [2:0] count;
  logic [1:0] lowest;
  logic       lowest_valid;

  int errors = 0;
  int checks = 0;

`ifdef REQ_LATCH_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  request_latch #(.WIDTH(4)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .in           (in),
    .clr          (clr),
    .out          (out),
    .any          (any),
    .count        (count),
    .lowest       (lowest),
    .lowest_valid (lowest_valid)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] e_out, input logic [2:0] e_cnt,
                         input logic [1:0] e_low);
    chk({tag, ".out"}, 32'(out), 32'(e_out));
    chk({tag, ".any"}, 32'(any), 32'(|e_out));
    chk({tag, ".count"}, 32'(count), 32'(e_cnt));
    chk({tag, ".lowest"}, 32'(lowest), 32'(e_low));
    chk({tag, ".lowest_valid"}, 32'(lowest_valid), 32'(|e_out));
  endtask

  initial begin
    #3;
    chk_all("in_reset", 4'b0000, 3'd0, 2'd0);
    #9;
    RESET = 1'b0;
    step();
    chk_all("after_release", 4'b0000, 3'd0, 2'd0);

    // set and hold
    in = 4'b0100;
    step();
    in = 4'b0000;
    chk_all("set_bit2", 4'b0100, 3'd1, 2'd2);
    for (int k = 0; k < 5; k++) begin
      step();
      chk_all("hold_bit2", 4'b0100, 3'd1, 2'd2);
    end

    // clear priority over a held request
    in = 4'b0010;
    step();
    chk_all("set_bit1", 4'b0110, 3'd2, 2'd1);
    clr = 4'b0010;
    step();
    chk_all("clr_beats_set", 4'b0100, 3'd1, 2'd2);
    clr = 4'b0000;
    step();
    if (EDGE) chk_all("release_edge", 4'b0100, 3'd1, 2'd2);
    else      chk_all("release_level", 4'b0110, 3'd2, 2'd1);
    in = 4'b0000;
    clr = 4'b1111;
    step();
    clr = 4'b0000;
    chk_all("clear_all_1", 4'b0000, 3'd0, 2'd0);

    // multi-bit count / priority
    in = 4'b1011;
    step();
    in = 4'b0000;
    chk_all("multi_set", 4'b1011, 3'd3, 2'd0);
    clr = 4'b0001;
    step();
    clr = 4'b0000;
    chk_all("multi_clr0", 4'b1010, 3'd2, 2'd1);

    // per-bit independence
    clr = 4'b1111;
    step();
    clr = 4'b0000;
    in = 4'b0001;
    step();
    chk_all("indep_pre", 4'b0001, 3'd1, 2'd0);
    in = 4'b1000;
    clr = 4'b0001;
    step();
    in = 4'b0000;
    clr = 4'b0000;
    chk_all("indep", 4'b1000, 3'd1, 2'd3);

    // held in[2] with clear in the second cycle
    clr = 4'b1111;
    step();
    clr = 4'b0000;
    in = 4'b0100;
    step();
    chk_all("held_c1", 4'b0100, 3'd1, 2'd2);
    clr = 4'b0100;
    step();
    clr = 4'b0000;
    chk_all("held_c2", 4'b0000, 3'd0, 2'd0);
    for (int k = 3; k <= 4; k++) begin
      step();
      if (EDGE) chk_all("held_edge_c34", 4'b0000, 3'd0, 2'd0);
      else      chk_all("held_level_c34", 4'b0100, 3'd1, 2'd2);
    end
    in = 4'b0000;
    clr = 4'b1111;
    step();
    clr = 4'b0000;

    // asynchronous reset mid-cycle
    in = 4'b1011;
    step();
    in = 4'b0000;
    chk_all("pre_reset", 4'b1011, 3'd3, 2'd0);
    #2;
    RESET = 1'b1;
    #1;
    chk_all("async_reset", 4'b0000, 3'd0, 2'd0);
    in = 4'b0001;
    #2;
    RESET = 1'b0;
    step();
    in = 4'b0000;
    chk_all("high_at_release", 4'b0001, 3'd1, 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/request_latch.md
# request_latch

Bank of sticky request latches for the elevator controller. Each bit captures a call-button press and holds it until the controller's state machine clears it after servicing. Summary outputs (any pending, pending count, lowest pending index) are derived from the latched bits for scheduling logic. Sits between the raw button inputs (F/U/D per floor) and the elevator state machine.

## Interface
- WIDTH, 4: number of independent request bits (≥1).
- CLK  input  1  rising-edge clock for all state.
- RESET  input  1  asynchronous, active-high; clears all state.
- in  input  WIDTH  request inputs; bit i high requests set of out[i].
- clr  input  WIDTH  per-bit clear; level-sensitive, sampled on CLK.
- out  output  WIDTH  latched request bits.
- any  output  1  OR of out.
- count  output  $clog2(WIDTH+1)  number of set bits in out.
- lowest  output  $clog2(WIDTH) (min 1)  index of lowest set bit of out; 0 when none.
- lowest_valid  output  1  equals any.

## Operation
- Per bit, on each rising CLK (RESET low):
  - clr[i]=1 → out[i] <= 0. Clear has priority over set; a set request in the same cycle is discarded.
  - else set condition true → out[i] <= 1.
  - else out[i] holds.
- Set condition: in[i]=1 (level mode), or rising edge of in[i] (edge mode, see Configuration).
- While clr[i] is held high for multiple cycles, out[i] stays 0 regardless of in[i].
- Bits are fully independent; any mix of set/clear/hold across bits in one cycle is legal.
- any, count, lowest, lowest_valid are purely combinational from out (no extra register stage).
- lowest is a priority encoder: bit 0 has highest priority.
- count is an unsigned popcount; it cannot overflow because its width covers WIDTH.

## Timing
- RESET asserted: out, and the edge-detect history register, go to 0 immediately (asynchronous), independent of CLK. Summary outputs follow combinationally: any=0, count=0, lowest=0, lowest_valid=0.
- RESET deasserted: first update occurs on the next rising CLK.
- Set latency: in[i] high before edge k → out[i]=1 after edge k (1 cycle).
- Clear latency: clr[i] high before edge k → out[i]=0 after edge k.
- Summary outputs are valid in the same cycle as out.
- in must be synchronous to CLK. Synchronization of asynchronous button inputs is handled upstream.

## Configuration
- REQ_LATCH_EDGE_EN defined: each bit registers the previous in[i] (reset value 0). The set condition is in[i] & ~prev[i]. A press held through a clr is not re-latched after clr drops. An input already high at reset release counts as an edge on the first clock.
- Undefined: level mode. A held in[i] re-sets out[i] on the first cycle after clr[i] deasserts. No history register is built.

## Structure
- Package req_latch_pkg holds:
  - the default WIDTH constant;
  - a function returning the count width, $clog2(WIDTH+1);
  - a function returning the index width, max(1, $clog2(WIDTH)).
- Sub-module request_latch_bit holds the single-bit set/clear flop and the optional edge history. It is instantiated WIDTH times in a generate loop.
- The popcount and the priority encoder live in the top module.

## Test plan
- Reset: assert RESET mid-cycle with out=4'b1011. Require out=0, any=0, count=0 before the next CLK edge.
- Set/hold: pulse in=4'b0100 for one cycle. Require out=4'b0100 after that edge, held for 5 further cycles with in=0, count=1, lowest=2.
- Clear priority: with out[1]=1, drive in[1]=1 and clr[1]=1 in the same cycle. Require out[1]=0. Release clr with in[1] still high: level mode → out[1]=1 next cycle; edge mode → out[1] stays 0.
- Multi-bit: set bits 3, 1, 0, then clear bit 0. Require count 3→2 and lowest 0→1, with any=1 throughout.
- Per-bit independence: in=4'b1000 with clr=4'b0001 while out=4'b0001. Require out=4'b1000 after one edge.
- Edge mode: hold in[2]=1 for 4 cycles, with clr[2] asserted in cycle 2. Require out[2]=1 after cycle 1, 0 after cycle 2, and still 0 after cycles 3–4.
